bsg_cache_non_blocking_dma_sched: RTL and testbench

//  Shares one bsg_cache_non_blocking_dma engine among num_req_p miss-handling units (MHUs).

---
 rtl/bsg_cache_non_blocking_dma_sched.sv | 140 ++++++++++++++
 tb/tb_bsg_cache_non_blocking_dma_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_non_blocking_dma_sched.sv
// Round-robin scheduler sharing one non-blocking DMA engine among MHUs.
// Optional per-requester issue counters: BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN.
module bsg_cache_non_blocking_dma_sched #(
  parameter int num_req_p       = 2,
  parameter int dma_cmd_width_p = 64,
  parameter int lg_req_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*dma_cmd_width_p-1:0] dma_cmd_i,
  input  logic [num_req_p-1:0]                 dma_cmd_v_i,
  output logic [num_req_p-1:0]                 dma_cmd_yumi_o,
  output logic [num_req_p-1:0]                 done_o,
  output logic [num_req_p-1:0]                 pending_o,
  input  logic [num_req_p-1:0]                 ack_i,
  output logic [dma_cmd_width_p-1:0]           dma_cmd_return_o,
  output logic [lg_req_lp-1:0]                 owner_id_o,
  output logic                                 owner_v_o,
  output logic [dma_cmd_width_p-1:0]           eng_dma_cmd_o,
  output logic                                 eng_dma_cmd_v_o,
  input  logic [dma_cmd_width_p-1:0]           eng_dma_cmd_return_i,
  input  logic                                 eng_done_i,
  input  logic                                 eng_pending_i,
`ifdef BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN
  output logic [num_req_p*16-1:0]              issue_cnt_o,
`endif
  output logic                                 eng_ack_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [lg_req_lp-1:0] rr_q, rr_d;
  logic [lg_req_lp-1:0] owner_q, owner_d;
  logic [lg_req_lp-1:0] pick;
  logic                 found;

  // State, round-robin pointer and owner registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Find the first valid requester at or after rr_q, wrapping
  always_comb begin
    int j;
    logic [lg_req_lp-1:0] idx;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      j = int'(rr_q) + i;
      if (j >= num_req_p) j = j - num_req_p;
      idx = lg_req_lp'(j);
      if (!found && dma_cmd_v_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic and outputs
  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    owner_d          = owner_q;
    dma_cmd_yumi_o   = '0;
    done_o           = '0;
    pending_o        = '0;
    eng_dma_cmd_v_o  = 1'b0;
    eng_ack_o        = 1'b0;
    eng_dma_cmd_o    = dma_cmd_i[owner_q*dma_cmd_width_p +: dma_cmd_width_p];
    dma_cmd_return_o = eng_dma_cmd_return_i;
    owner_id_o       = owner_q;
    owner_v_o        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_dma_cmd_v_o         = 1'b1;
        dma_cmd_yumi_o[owner_q] = 1'b1;
        // With a single requester this always wraps to 0
        if (owner_q == lg_req_lp'(num_req_p - 1)) rr_d = '0;
        else rr_d = owner_q + 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        pending_o[owner_q] = eng_pending_i;
        done_o[owner_q]    = eng_done_i;
        eng_ack_o          = eng_done_i & ack_i[owner_q];
        if (eng_ack_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN
  logic [num_req_p*16-1:0] cnt_q, cnt_d;

  // Saturating per-requester issue counters
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < num_req_p; i++) begin
      if (dma_cmd_yumi_o[i] && cnt_q[i*16 +: 16] != 16'hFFFF)
        cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign issue_cnt_o = cnt_q;
`endif

  // The granted MHU must keep its request up while its cmd is issued
  a_v_held_in_issue: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (state_q == ISSUE) |-> dma_cmd_v_i[owner_q]
  );

endmodule

// File: tb/tb_bsg_cache_non_blocking_dma_sched.sv
// Directed bench for bsg_cache_non_blocking_dma_sched, three requesters.
// Define BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN to also cover the counters.
module tb_bsg_cache_non_blocking_dma_sched;

  localparam int N = 3;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] dma_cmd_i;
  logic [N-1:0]   dma_cmd_v_i;
  logic [N-1:0]   dma_cmd_yumi_o;
  logic [N-1:0]   done_o;
  logic [N-1:0]   pending_o;
  logic [N-1:0]   ack_i;
  logic [W-1:0]   dma_cmd_return_o;
  logic [1:0]     owner_id_o;
  logic           owner_v_o;
  logic [W-1:0]   eng_dma_cmd_o;
  logic           eng_dma_cmd_v_o;
  logic [W-1:0]   eng_dma_cmd_return_i;
  logic           eng_done_i;
  logic           eng_pending_i;
  logic           eng_ack_o;
`ifdef BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN
  logic [N*16-1:0] issue_cnt_o;
`endif

  bsg_cache_non_blocking_dma_sched #(
    .num_req_p(N),
    .dma_cmd_width_p(W)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .dma_cmd_i(dma_cmd_i),
    .dma_cmd_v_i(dma_cmd_v_i),
    .dma_cmd_yumi_o(dma_cmd_yumi_o),
    .done_o(done_o),
    .pending_o(pending_o),
    .ack_i(ack_i),
    .dma_cmd_return_o(dma_cmd_return_o),
    .owner_id_o(owner_id_o),
    .owner_v_o(owner_v_o),
    .eng_dma_cmd_o(eng_dma_cmd_o),
    .eng_dma_cmd_v_o(eng_dma_cmd_v_o),
    .eng_dma_cmd_return_i(eng_dma_cmd_return_i),
    .eng_done_i(eng_done_i),
    .eng_pending_i(eng_pending_i),
`ifdef BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN
    .issue_cnt_o(issue_cnt_o),
`endif
    .eng_ack_o(eng_ack_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] cmds [N];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Spacing between engine cmd pulses, sampled each negedge
  int cyc  = 0;
  int last = -1;
  bit gap_on = 1'b0;
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (gap_on && eng_dma_cmd_v_o) begin
      if (last >= 0) chk("eng_v_gap", 64'((cyc - last) >= 2), 64'd1);
      last = cyc;
    end
  end

  // Request with mask v, expect grant to exp_o; optionally run BUSY to ack
  task automatic grant(input logic [N-1:0] v, input int exp_o,
                       input bit busy);
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << exp_o;
    dma_cmd_v_i = v;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!eng_dma_cmd_v_o && n < 8);
    chk("issue_latency", 64'(n), 64'd1);
    chk("owner_id", 64'(owner_id_o), 64'(exp_o));
    chk("yumi", 64'(dma_cmd_yumi_o), 64'(oh));
    chk("eng_cmd", eng_dma_cmd_o, cmds[exp_o]);
    if (busy) begin
      @(negedge clk);
      eng_pending_i = 1'b1;
      #1;
      chk("pending", 64'(pending_o), 64'(oh));
      chk("busy_no_v", 64'(eng_dma_cmd_v_o), 64'd0);
      @(negedge clk);
      eng_pending_i = 1'b0;
      eng_done_i = 1'b1;
      #1;
      chk("done", 64'(done_o), 64'(oh));
      chk("no_ack_yet", 64'(eng_ack_o), 64'd0);
      @(negedge clk);
      ack_i = oh;
      #1;
      chk("eng_ack", 64'(eng_ack_o), 64'd1);
      @(negedge clk);
      ack_i = '0;
      eng_done_i = 1'b0;
      #1;
      chk("back_idle", 64'(owner_v_o), 64'd0);
    end
  endtask

  initial begin
    cmds[0] = 64'h0000_0000_0000_00A5;
    cmds[1] = 64'h1111_2222_3333_4444;
    cmds[2] = 64'hCAFE_F00D_0BAD_BEEF;
    dma_cmd_i = {cmds[2], cmds[1], cmds[0]};
    reset_i = 1'b1;
    dma_cmd_v_i = '0;
    ack_i = '0;
    eng_done_i = 1'b0;
    eng_pending_i = 1'b0;
    eng_dma_cmd_return_i = 64'h0123_4567_89AB_CDEF;
    #12;
    chk("rst_outs", 64'({dma_cmd_yumi_o, done_o, pending_o, owner_v_o,
                         eng_dma_cmd_v_o, eng_ack_o}), 64'd0);
    chk("cmd_return", dma_cmd_return_o, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("idle_quiet", 64'({dma_cmd_yumi_o, eng_dma_cmd_v_o}), 64'd0);

    gap_on = 1'b1;
    grant(3'b111, 0, 1'b1);
    grant(3'b111, 1, 1'b1);
    grant(3'b111, 2, 1'b1);
    grant(3'b111, 0, 1'b1);
    gap_on = 1'b0;

    grant(3'b001, 0, 1'b1);

    grant(3'b010, 1, 1'b0);
    @(negedge clk);
    dma_cmd_v_i = '0;
    eng_done_i = 1'b1;
    ack_i = 3'b001;
    #1;
    chk("nonowner_ack", 64'(eng_ack_o), 64'd0);
    chk("done_owner1", 64'(done_o), 64'(3'b010));
    @(negedge clk);
    #1;
    chk("stay_busy", 64'(owner_v_o), 64'd1);
    ack_i = 3'b010;
    #1;
    chk("owner_ack", 64'(eng_ack_o), 64'd1);
    @(negedge clk);
    ack_i = '0;
    eng_done_i = 1'b0;
    #1;
    chk("ack_idle", 64'(owner_v_o), 64'd0);

    grant(3'b001, 0, 1'b0);
    @(negedge clk);
    dma_cmd_v_i = '0;
    eng_pending_i = 1'b1;
    eng_done_i = 1'b1;
    #1;
    chk("pend_pre_rst", 64'(pending_o), 64'(3'b001));
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_mid", 64'({dma_cmd_yumi_o, done_o, pending_o, owner_v_o,
                        eng_dma_cmd_v_o, eng_ack_o}), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    eng_pending_i = 1'b0;
    eng_done_i = 1'b0;
    grant(3'b011, 0, 1'b1);
    grant(3'b010, 1, 1'b1);
    dma_cmd_v_i = '0;

`ifdef BSG_CACHE_NON_BLOCKING_DMA_SCHED_STATS_EN
    begin
      logic [N*16-1:0] pre;
      pre = dut.cnt_q;
      pre[15:0] = 16'hFFFE;
      force dut.cnt_q = pre;
      #1;
      release dut.cnt_q;
      for (int k = 0; k < 3; k++) begin
        grant(3'b001, 0, 1'b1);
        chk("cnt_sat", 64'(issue_cnt_o[15:0]), 64'hFFFF);
      end
      dma_cmd_v_i = '0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
